// File: rtl/fifo_stream_output_stage_pkg.sv
// Shared definitions for the FIFO stream output stage: local occupancy encodings.
package fifo_stream_output_stage_pkg;

  // Number of words held locally by the output stage (head plus skid).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_stream_output_stage_if.sv
// Valid/ready stream interface carried between the output stage and its consumer.
interface fifo_stream_output_stage_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Producer side: drives valid/data, receives ready.
  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Consumer side: receives valid/data, drives ready.
  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_stream_output_storage.sv
// Head and skid word registers for the output stage. The head register is the
// visible output word; the skid register absorbs one extra word read from the
// FIFO while the consumer is stalled.
module fifo_stream_output_storage #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             load_head,   // head <= in_data
  input  logic             shift_skid,  // head <= skid
  input  logic             load_skid,   // skid <= in_data
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] skid
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] skid_reg;

  // Word registers; shift and skid load may happen together in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (shift_skid) begin
        head_reg <= skid_reg;
      end else if (load_head) begin
        head_reg <= in_data;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

  assign head = head_reg;
  assign skid = skid_reg;

endmodule

// File: rtl/fifo_stream_output_stage.sv
// Two-entry output stage between a FIFO controller (read strobe, same-cycle
// head data) and a valid/ready stream consumer. Sustains one word per cycle,
// keeps out_valid independent of out_ready, and counts completed handshakes.
module fifo_stream_output_stage
  import fifo_stream_output_stage_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  input  logic [WIDTH-1:0]       fifo_read_data,
  fifo_stream_output_stage_if.master stream,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] transfer_count
);

  occ_t                   occ_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  logic             out_valid;
  logic             pop;
  logic             read;
  logic             load_head;
  logic             shift_skid;
  logic             load_skid;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;

  // Valid depends only on local state and flush, never on out_ready.
  assign out_valid = (occ_reg != OCC_EMPTY) & ~flush;
  assign pop       = out_valid & stream.out_ready;
  // A read is only issued when there is room now or a pop frees room this cycle.
  assign read      = ~fifo_empty & ~flush & ((occ_reg != OCC_TWO) | pop);

  // Decode storage controls from occupancy, read and pop.
  always_comb begin
    load_head  = 1'b0;
    shift_skid = 1'b0;
    load_skid  = 1'b0;
    unique case (occ_reg)
      OCC_EMPTY: begin
        load_head = read;
      end
      OCC_ONE: begin
        load_head = read & pop;
        load_skid = read & ~pop;
      end
      OCC_TWO: begin
        shift_skid = pop;
        load_skid  = pop & read;
      end
      default: begin
        load_head  = 1'b0;
      end
    endcase
  end

  fifo_stream_output_storage #(
    .WIDTH(WIDTH)
  ) u_storage (
    .clock      (clock),
    .reset      (reset),
    .in_data    (fifo_read_data),
    .load_head  (load_head),
    .shift_skid (shift_skid),
    .load_skid  (load_skid),
    .head       (head),
    .skid       (skid)
  );

  // Occupancy FSM; reset beats flush, flush beats read/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_reg <= OCC_EMPTY;
    end else if (flush) begin
      occ_reg <= OCC_EMPTY;
    end else begin
      unique case (occ_reg)
        OCC_EMPTY: begin
          if (read) occ_reg <= OCC_ONE;
        end
        OCC_ONE: begin
          if (read & ~pop)      occ_reg <= OCC_TWO;
          else if (~read & pop) occ_reg <= OCC_EMPTY;
        end
        OCC_TWO: begin
          if (pop & ~read) occ_reg <= OCC_ONE;
        end
        default: begin
          occ_reg <= OCC_EMPTY;
        end
      endcase
    end
  end

  // Handshake counter; wraps naturally and ignores flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (pop) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign fifo_read_enable = read;
  assign stream.out_valid = out_valid;
  assign stream.out_data  = head;
  assign occupancy        = occ_reg;
  assign transfer_count   = count_reg;

  // The skid word only reaches the output through the head register.
  logic unused_skid;
  assign unused_skid = ^skid;

endmodule

// File: tb/tb_fifo_stream_output_stage.sv
// Directed bench for fifo_stream_output_stage: a cycle table plus a release
// sequence driven from a small FIFO model. A second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_fifo_stream_output_stage;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       fifo_empty;
  logic [7:0] fifo_read_data;
  logic       ready;

  logic        rd_a, rd_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  fifo_stream_output_stage_if #(.WIDTH(8)) s_a ();
  fifo_stream_output_stage_if #(.WIDTH(8)) s_b ();
  assign s_a.out_ready = ready;
  assign s_b.out_ready = ready;

  fifo_stream_output_stage #(.WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (rd_a),
    .fifo_read_data   (fifo_read_data),
    .stream           (s_a),
    .occupancy        (occ_a),
    .transfer_count   (cnt_a)
  );

  fifo_stream_output_stage #(.WIDTH(8), .COUNT_WIDTH(2)) dut_wrap (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (rd_b),
    .fifo_read_data   (fifo_read_data),
    .stream           (s_b),
    .occupancy        (occ_b),
    .transfer_count   (cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        emp;
    logic [7:0]  rdat;
    logic        rdy;
    logic        e_rd;
    logic        e_val;
    logic [7:0]  e_dat;
    logic        chk_dat;
    logic [1:0]  e_occ;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vec [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q [$];
  logic [7:0] exp_seq [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic emp,
                              input logic [7:0] rdat, input logic rdy,
                              input logic e_rd, input logic e_val, input logic [7:0] e_dat,
                              input logic chk_dat, input logic [1:0] e_occ,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.emp = emp; v.rdat = rdat; v.rdy = rdy;
    v.e_rd = e_rd; v.e_val = e_val; v.e_dat = e_dat; v.chk_dat = chk_dat;
    v.e_occ = e_occ; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive_from_fifo();
    fifo_empty     = (q.size() == 0);
    fifo_read_data = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  initial begin
    //            rst fl emp rdat  rdy  rd val dat   chk occ cnt
    // reset state
    vec[0]  = mk(0, 0, 1, 8'h00, 1,   0, 0, 8'h00, 1, 0, 0);
    // streaming 11,22,33 with ready high
    vec[1]  = mk(0, 0, 0, 8'h11, 1,   1, 0, 8'h00, 1, 0, 0);
    vec[2]  = mk(0, 0, 0, 8'h22, 1,   1, 1, 8'h11, 1, 1, 0);
    vec[3]  = mk(0, 0, 0, 8'h33, 1,   1, 1, 8'h22, 1, 1, 1);
    vec[4]  = mk(0, 0, 1, 8'h00, 1,   0, 1, 8'h33, 1, 1, 2);
    vec[5]  = mk(0, 0, 1, 8'h00, 1,   0, 0, 8'h33, 1, 0, 3);
    // backpressure: fill to two, then reads stop and output holds
    vec[6]  = mk(0, 0, 0, 8'h44, 0,   1, 0, 8'h33, 1, 0, 3);
    vec[7]  = mk(0, 0, 0, 8'h55, 0,   1, 1, 8'h44, 1, 1, 3);
    vec[8]  = mk(0, 0, 0, 8'h66, 0,   0, 1, 8'h44, 1, 2, 3);
    vec[9]  = mk(0, 0, 0, 8'h66, 0,   0, 1, 8'h44, 1, 2, 3);
    // release: pop and read together keep occupancy at two
    vec[10] = mk(0, 0, 0, 8'h66, 1,   1, 1, 8'h44, 1, 2, 3);
    vec[11] = mk(0, 0, 0, 8'h77, 1,   1, 1, 8'h55, 1, 2, 4);
    vec[12] = mk(0, 0, 1, 8'h00, 1,   0, 1, 8'h66, 1, 2, 5);
    vec[13] = mk(0, 0, 1, 8'h00, 1,   0, 1, 8'h77, 1, 1, 6);
    vec[14] = mk(0, 0, 1, 8'h00, 0,   0, 0, 8'h77, 1, 0, 7);
    // flush at occupancy two
    vec[15] = mk(0, 0, 0, 8'h88, 0,   1, 0, 8'h77, 1, 0, 7);
    vec[16] = mk(0, 0, 0, 8'h99, 0,   1, 1, 8'h88, 1, 1, 7);
    vec[17] = mk(0, 1, 0, 8'hAA, 1,   0, 0, 8'h00, 0, 2, 7);
    vec[18] = mk(0, 0, 0, 8'hAA, 1,   1, 0, 8'h00, 0, 0, 7);
    vec[19] = mk(0, 0, 1, 8'h00, 1,   0, 1, 8'hAA, 1, 1, 7);
    vec[20] = mk(0, 0, 1, 8'h00, 1,   0, 0, 8'hAA, 1, 0, 8);
    // reset mid-stream at occupancy one
    vec[21] = mk(0, 0, 0, 8'hBB, 0,   1, 0, 8'hAA, 1, 0, 8);
    vec[22] = mk(1, 0, 0, 8'hCC, 0,   1, 1, 8'hBB, 1, 1, 8);
    vec[23] = mk(0, 0, 1, 8'h00, 1,   0, 0, 8'h00, 1, 0, 0);

    exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3;
    exp_seq[3] = 8'hA4; exp_seq[4] = 8'hA5;

    reset = 1'b1; flush = 1'b0; fifo_empty = 1'b1; fifo_read_data = 8'h00; ready = 1'b0;
    repeat (2) @(posedge clock);

    // Table: drive on the falling edge, sample 1 ns later, then take the rising edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      reset = vec[i].rst; flush = vec[i].fl; fifo_empty = vec[i].emp;
      fifo_read_data = vec[i].rdat; ready = vec[i].rdy;
      #1;
      $display("vec %0d: rd=%0b valid=%0b data=%02h occ=%0d cnt=%0d cnt2=%0d",
               i, rd_a, s_a.out_valid, s_a.out_data, occ_a, cnt_a, cnt_b);
      check($sformatf("v%0d read_enable", i), {31'd0, rd_a}, {31'd0, vec[i].e_rd});
      check($sformatf("v%0d out_valid", i), {31'd0, s_a.out_valid}, {31'd0, vec[i].e_val});
      if (vec[i].chk_dat)
        check($sformatf("v%0d out_data", i), {24'd0, s_a.out_data}, {24'd0, vec[i].e_dat});
      check($sformatf("v%0d occupancy", i), {30'd0, occ_a}, {30'd0, vec[i].e_occ});
      check($sformatf("v%0d transfer_count", i), {16'd0, cnt_a}, {16'd0, vec[i].e_cnt});
      check($sformatf("v%0d count_wrap", i), {30'd0, cnt_b}, {30'd0, vec[i].e_cnt[1:0]});
      check($sformatf("v%0d read_error", i), {31'd0, rd_a & fifo_empty}, 32'd0);
    end

    // Release sequence: FIFO holds A1..A5, consumer stalls, then drains.
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int c = 0; c < 4; c++) begin
      logic rd_s;
      @(negedge clock);
      reset = 1'b0; flush = 1'b0; ready = 1'b0;
      drive_from_fifo();
      #1;
      rd_s = rd_a;
      $display("stall %0d: rd=%0b valid=%0b data=%02h occ=%0d", c, rd_a, s_a.out_valid, s_a.out_data, occ_a);
      check($sformatf("stall%0d read_error", c), {31'd0, rd_a & fifo_empty}, 32'd0);
      if (c >= 2) begin
        check($sformatf("stall%0d occupancy", c), {30'd0, occ_a}, 32'd2);
        check($sformatf("stall%0d read_enable", c), {31'd0, rd_a}, 32'd0);
        check($sformatf("stall%0d out_data", c), {24'd0, s_a.out_data}, 32'hA1);
      end
      @(posedge clock);
      if (rd_s) void'(q.pop_front());
    end

    begin
      int pops;
      pops = 0;
      for (int c = 0; c < 20 && pops < 5; c++) begin
        logic rd_s;
        @(negedge clock);
        ready = 1'b1;
        drive_from_fifo();
        #1;
        rd_s = rd_a;
        check($sformatf("rel%0d read_error", c), {31'd0, rd_a & fifo_empty}, 32'd0);
        if (s_a.out_valid && ready) begin
          $display("release pop %0d: data=%02h occ=%0d", pops, s_a.out_data, occ_a);
          check($sformatf("rel pop%0d out_data", pops), {24'd0, s_a.out_data}, {24'd0, exp_seq[pops]});
          check($sformatf("rel pop%0d occupancy", pops), {30'd0, occ_a}, (pops < 4) ? 32'd2 : 32'd1);
          pops++;
        end
        @(posedge clock);
        if (rd_s) void'(q.pop_front());
      end
      check("release pop total", pops, 32'd5);
    end

    @(negedge clock);
    ready = 1'b1;
    drive_from_fifo();
    #1;
    $display("after release: valid=%0b occ=%0d cnt=%0d cnt2=%0d", s_a.out_valid, occ_a, cnt_a, cnt_b);
    check("final out_valid", {31'd0, s_a.out_valid}, 32'd0);
    check("final occupancy", {30'd0, occ_a}, 32'd0);
    check("final transfer_count", {16'd0, cnt_a}, 32'd5);
    check("final count_wrap", {30'd0, cnt_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
